sad_result_serializer: RTL and testbench

- Output stage of the motion-estimation SAD engine.
- Accepts one parallel result per request: two 4-bit best-point indices and two 24-bit SADs.
- Buffers results in a small FIFO and transmits each as a 56-bit serial frame on out_valid/out_sad, LSB first.
- This is the transmitting end of the serial result interface whose receiver counts exactly 56 out_valid-high cycles per frame.

---
 rtl/sad_result_serializer_if.sv | 39 +++
 rtl/sad_result_serializer.sv | 164 ++++++++++++++++
 tb/tb_sad_result_serializer.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sad_result_serializer_if.sv
// sad_result_serializer_if: parallel result request bus plus the serial
// frame output of the SAD result serializer.
// slave  - serializer side (accepts results, drives the serial frame).
// master - producer/observer side.
interface sad_result_serializer_if;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_point0;
    logic [23:0] res_sad0;
    logic [3:0]  res_point1;
    logic [23:0] res_sad1;
    logic        out_valid;
    logic        out_sad;
    logic        busy;

    modport slave (
        input  res_valid,
        input  res_point0,
        input  res_sad0,
        input  res_point1,
        input  res_sad1,
        output res_ready,
        output out_valid,
        output out_sad,
        output busy
    );

    modport master (
        output res_valid,
        output res_point0,
        output res_sad0,
        output res_point1,
        output res_sad1,
        input  res_ready,
        input  out_valid,
        input  out_sad,
        input  busy
    );
endinterface

// File: rtl/sad_result_serializer.sv
// sad_result_serializer: output stage of the motion-estimation SAD engine.
// Buffers parallel results {point1, sad1, point0, sad0} in a DEPTH-entry FIFO
// and transmits each as a 56-bit serial frame on out_valid/out_sad, LSB first.
// Build macro SER_IDLE_GAP_EN: when defined, the inter-frame GAP state lasts
// IDLE_GAP cycles (4-bit gap counter); otherwise GAP is a single cycle.
module sad_result_serializer #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned IDLE_GAP = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    sad_result_serializer_if.slave bus
);
    localparam int unsigned FRAME_W = 56;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned BCW     = 6;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_W - 1);

    // Reject configurations the pointer/gap logic cannot represent.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IDLE_GAP < 1 || IDLE_GAP > 15) begin : g_bad_params
        $error("sad_result_serializer: DEPTH must be a power of 2 >= 2 and IDLE_GAP in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [FRAME_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [FRAME_W-1:0] r_shift;
    logic [BCW-1:0]     r_bit_cnt;
    logic               r_out_valid;
    logic               r_out_sad;
    logic               r_ready;
    logic               r_busy;
    logic               w_push;
    logic               w_pop;
    logic               w_shift_en;
    logic               w_gap_done;
    logic               w_out_valid_next;
    logic               w_out_sad_next;
    logic [CW-1:0]      w_count_next;
    logic [FRAME_W-1:0] w_frame;

    assign w_frame      = {bus.res_point1, bus.res_sad1, bus.res_point0, bus.res_sad0};
    assign w_push       = bus.res_valid && r_ready;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

`ifdef SER_IDLE_GAP_EN
    localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);
    logic [3:0] r_gap_cnt;

    // Count cycles spent in GAP; held at zero elsewhere so each GAP starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_cnt <= '0;
        end else if (r_state == S_GAP) begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
        end else begin
            r_gap_cnt <= '0;
        end
    end

    assign w_gap_done = (r_gap_cnt == GAP_LAST);
`else
    assign w_gap_done = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state, FIFO pop and next values of the serial outputs.
    always_comb begin
        w_state_next     = r_state;
        w_pop            = 1'b0;
        w_shift_en       = 1'b0;
        w_out_valid_next = 1'b0;
        w_out_sad_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_out_valid_next = 1'b1;
                w_out_sad_next   = r_shift[0];
                w_shift_en       = 1'b1;
                if (r_bit_cnt == LAST_BIT) begin
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_frame;
        end
    end

    // FIFO pointers/count, shift register, bit counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_sad   <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_shift   <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_shift   <= {1'b0, r_shift[FRAME_W-1:1]};
                r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
            r_count     <= w_count_next;
            r_out_valid <= w_out_valid_next;
            r_out_sad   <= w_out_sad_next;
            // ready/busy are registered from next-state values so they
            // always equal !full and (non-empty || not IDLE) of the current regs.
            r_ready     <= (w_count_next != CW'(DEPTH));
            r_busy      <= (w_count_next != '0) || (w_state_next != S_IDLE);
        end
    end

    assign bus.res_ready = r_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sad   = r_out_sad;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_sad_result_serializer.sv
// tb_sad_result_serializer: scoreboard bench for sad_result_serializer.
// Expected frames are queued at push time; a negedge monitor reassembles
// serial frames which each test task pops and compares in order.
module tb_sad_result_serializer;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned IDLE_GAP = 3;
    localparam int          FRAME_BITS = 56;
`ifdef SER_IDLE_GAP_EN
    localparam int MIN_LOW = IDLE_GAP + 1;
`else
    localparam int MIN_LOW = 2;
`endif

    typedef struct {
        logic [55:0] data;
        int          len;
        int          gap;
        int          start_edge;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sad_result_serializer_if bus ();

    sad_result_serializer #(
        .DEPTH    (DEPTH),
        .IDLE_GAP (IDLE_GAP)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          total       = 0;
    int          bad         = 0;
    int          edge_cnt    = 0;
    int          sad_low_err = 0;
    logic [55:0] exp_q [$];
    frame_t      got_q [$];
    bit          in_frame    = 1'b0;
    int          run_len     = 0;
    int          low_run     = 0;
    frame_t      cur;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Frame reassembly; a reset discards any partial frame.
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            run_len  = 0;
            low_run  = 0;
        end else if (bus.out_valid === 1'b1) begin
            if (!in_frame) begin
                in_frame       = 1'b1;
                run_len        = 0;
                cur.data       = '0;
                cur.gap        = low_run;
                cur.start_edge = edge_cnt;
            end
            if (run_len < FRAME_BITS) cur.data[run_len] = bus.out_sad;
            run_len++;
        end else begin
            if (in_frame) begin
                cur.len = run_len;
                got_q.push_back(cur);
                in_frame = 1'b0;
                low_run  = 0;
            end
            low_run++;
            if (bus.out_sad !== 1'b0) sad_low_err++;
        end
    end

    function automatic logic [55:0] rand_word();
        return {4'($urandom), 24'($urandom), 4'($urandom), 24'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.res_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Present one result for one edge; edge_n is the edge that sampled it.
    task automatic push(input logic [55:0] w, input bit exp_acc, output logic rdy, output int edge_n);
        bus.res_valid  = 1'b1;
        bus.res_sad0   = w[23:0];
        bus.res_point0 = w[27:24];
        bus.res_sad1   = w[51:28];
        bus.res_point1 = w[55:52];
        rdy = bus.res_ready;
        if (exp_acc) exp_q.push_back(w);
        tick();
        edge_n = edge_cnt;
        bus.res_valid = 1'b0;
    endtask

    // Wait (bounded) for res_ready, then push.
    task automatic send(input logic [55:0] w, output int ready_edge, output int edge_n);
        int   guard;
        logic rdy;
        guard  = 0;
        edge_n = 0;
        while (bus.res_ready !== 1'b1 && guard < 400) begin
            tick();
            guard++;
        end
        ready_edge = edge_cnt;
        total++;
        if (bus.res_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready_timeout: res_ready=%b after %0d cycles, required 1", bus.res_ready, guard);
        end else begin
            push(w, 1'b1, rdy, edge_n);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.res_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid c%0d: got %b want 0", i, bus.out_valid); end
            total++;
            if (bus.out_sad !== 1'b0) begin bad++; $display("FAIL reset_out_sad c%0d: got %b want 0", i, bus.out_sad); end
            total++;
            if (bus.res_ready !== 1'b1) begin bad++; $display("FAIL reset_res_ready c%0d: got %b want 1", i, bus.res_ready); end
            total++;
            if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy c%0d: got %b want 0", i, bus.busy); end
        end
        tick();
    endtask

    task automatic test_single();
        logic [55:0] w = 56'hC123456_3000A5C;
        logic        rdy;
        int          n;
        frame_t      f;
        logic [55:0] e;
        push(w, 1'b1, rdy, n);
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL single_accept: res_ready=%b want 1", rdy); end
        wait_frames(1, 200);
        total++;
        if (got_q.size() < 1) begin
            bad++;
            $display("FAIL single_timeout: frames=%0d want 1", got_q.size());
        end else begin
            f = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (f.start_edge !== n + 2) begin bad++; $display("FAIL single_latency: first bit at edge %0d want %0d", f.start_edge, n + 2); end
            total++;
            if (f.len !== FRAME_BITS) begin bad++; $display("FAIL single_len: %0d want %0d", f.len, FRAME_BITS); end
            total++;
            if (f.data !== e) begin bad++; $display("FAIL single_data: got %h want %h", f.data, e); end
        end
        idle(10);
        total++;
        if (sad_low_err !== 0) begin bad++; $display("FAIL single_sad_low: %0d cycles with out_sad=1 while idle, want 0", sad_low_err); end
    endtask

    task automatic test_back_to_back();
        logic [55:0] w [5];
        bit          exp_acc [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        rdy;
        int          n;
        int          n0;
        int          r_edge;
        frame_t      f;
        logic [55:0] e;
        n0 = 0;
        for (int i = 0; i < 5; i++) w[i] = rand_word();
        // Third push fills the FIFO because the first entry leaves immediately.
        for (int i = 0; i < 5; i++) begin
            push(w[i], exp_acc[i], rdy, n);
            if (i == 0) n0 = n;
            total++;
            if (rdy !== exp_acc[i]) begin bad++; $display("FAIL b2b_accept[%0d]: res_ready=%b want %b", i, rdy, exp_acc[i]); end
        end
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", bus.busy); end
        total++;
        if (bus.res_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready: got %b want 0", bus.res_ready); end
        send(w[3], r_edge, n);
        wait_frames(4, 500);
        total++;
        if (got_q.size() < 4) begin
            bad++;
            $display("FAIL b2b_frames: got %0d want 4", got_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                f = got_q.pop_front();
                e = exp_q.pop_front();
                total++;
                if (f.data !== e) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", k, f.data, e); end
                total++;
                if (f.len !== FRAME_BITS) begin bad++; $display("FAIL b2b_len[%0d]: %0d want %0d", k, f.len, FRAME_BITS); end
                if (k == 0) begin
                    total++;
                    if (f.start_edge !== n0 + 2) begin bad++; $display("FAIL b2b_latency: edge %0d want %0d", f.start_edge, n0 + 2); end
                end else begin
                    total++;
                    if (f.gap !== MIN_LOW) begin bad++; $display("FAIL b2b_gap[%0d]: %0d low cycles want %0d", k, f.gap, MIN_LOW); end
                end
                if (k == 1) begin
                    total++;
                    if (f.start_edge !== r_edge + 1) begin bad++; $display("FAIL b2b_ready_rise: frame at edge %0d, ready rose at %0d, want frame one edge later", f.start_edge, r_edge); end
                end
            end
        end
        idle(150);
        total++;
        if (got_q.size() !== 0 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL b2b_extra: leftover frames=%0d expected=%0d want 0/0", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_extremes();
        logic [55:0] w_ones  = {4'hF, 24'hFFFFFF, 4'hF, 24'hFFFFFF};
        logic [55:0] w_zeros = '0;
        logic        rdy;
        int          n;
        frame_t      f;
        logic [55:0] e;
        push(w_ones, 1'b1, rdy, n);
        push(w_zeros, 1'b1, rdy, n);
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL ext_accept: res_ready=%b want 1", rdy); end
        wait_frames(2, 300);
        total++;
        if (got_q.size() < 2) begin
            bad++;
            $display("FAIL ext_frames: got %0d want 2", got_q.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                f = got_q.pop_front();
                e = exp_q.pop_front();
                total++;
                if (f.data !== e) begin bad++; $display("FAIL ext_data[%0d]: got %h want %h", k, f.data, e); end
                total++;
                if (f.len !== FRAME_BITS) begin bad++; $display("FAIL ext_len[%0d]: %0d want %0d", k, f.len, FRAME_BITS); end
            end
            total++;
            if (f.gap !== MIN_LOW) begin bad++; $display("FAIL ext_gap: %0d low cycles want %0d", f.gap, MIN_LOW); end
        end
        idle(10);
        total++;
        if (sad_low_err !== 0) begin bad++; $display("FAIL ext_sad_low: %0d cycles with out_sad=1 while idle, want 0", sad_low_err); end
    endtask

    task automatic test_reset_mid_frame();
        logic        rdy;
        int          n;
        int          k;
        frame_t      f;
        logic [55:0] e;
        push(rand_word(), 1'b1, rdy, n);
        push(rand_word(), 1'b1, rdy, n);
        k = 0;
        while (bus.out_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        total++;
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_start: out_valid=%b after %0d cycles want 1", bus.out_valid, k); end
        repeat (20) tick();
        total++;
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_in_frame: out_valid=%b at bit 20 want 1", bus.out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
        total++;
        if (bus.out_sad !== 1'b0) begin bad++; $display("FAIL mid_out_sad: got %b want 0", bus.out_sad); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
        total++;
        if (bus.res_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", bus.res_ready); end
        tick();
        idle(150);
        total++;
        if (got_q.size() !== 0) begin bad++; $display("FAIL mid_no_frames: got %0d frames after reset want 0", got_q.size()); end
        got_q.delete();
        push(rand_word(), 1'b1, rdy, n);
        wait_frames(1, 200);
        total++;
        if (got_q.size() < 1) begin
            bad++;
            $display("FAIL mid_new_frame: got %0d frames want 1", got_q.size());
        end else begin
            f = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (f.data !== e) begin bad++; $display("FAIL mid_data: got %h want %h", f.data, e); end
            total++;
            if (f.len !== FRAME_BITS) begin bad++; $display("FAIL mid_len: %0d want %0d", f.len, FRAME_BITS); end
            total++;
            if (f.start_edge !== n + 2) begin bad++; $display("FAIL mid_latency: edge %0d want %0d", f.start_edge, n + 2); end
        end
        idle(10);
    endtask

    task automatic test_soak();
        int          re;
        int          n;
        int          idx;
        frame_t      f;
        logic [55:0] e;
        for (int i = 0; i < 64; i++) begin
            send(rand_word(), re, n);
            idle(int'($urandom_range(0, 5)));
        end
        wait_frames(64, 1000);
        total++;
        if (got_q.size() !== 64) begin bad++; $display("FAIL soak_count: got %0d frames want 64", got_q.size()); end
        idx = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            f = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (f.data !== e) begin bad++; $display("FAIL soak_data[%0d]: got %h want %h", idx, f.data, e); end
            total++;
            if (f.len !== FRAME_BITS) begin bad++; $display("FAIL soak_len[%0d]: %0d want %0d", idx, f.len, FRAME_BITS); end
            total++;
            if (f.gap < MIN_LOW) begin bad++; $display("FAIL soak_gap[%0d]: %0d low cycles want >= %0d", idx, f.gap, MIN_LOW); end
            idx++;
        end
        total++;
        if (sad_low_err !== 0) begin bad++; $display("FAIL soak_sad_low: %0d cycles with out_sad=1 while idle, want 0", sad_low_err); end
    endtask

    initial begin
        bus.res_valid  = 1'b0;
        bus.res_point0 = '0;
        bus.res_sad0   = '0;
        bus.res_point1 = '0;
        bus.res_sad1   = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_extremes();
        test_reset_mid_frame();
        test_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before completion, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
